or1200_vlx_packer: RTL

- Parametrised variable-length-code bit packer for the OR1200 VLX (JPEG Huffman) path.
- Accepts codes of 0..MAX_LEN bits over a valid/ready handshake and packs them MSB-first into an accumulator.
- Extracts whole bytes, inserts JPEG 0x00 stuffing after every 0xFF byte (STUFF_EN), and emits big-endian DATA_W words on a valid/ready output.
- A flush pads to a byte boundary with 1s and emits a final partial word tagged with its byte count.

---
 rtl/or1200_vlx_packer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/or1200_vlx_packer.sv
// ---------------------------------------------------------------------------
// or1200_vlx_packer
//
// Variable-length-code bit packer for the OR1200 VLX (JPEG Huffman) path.
// Codes of 0..MAX_LEN bits are appended MSB-first to an accumulator. Whole
// bytes are peeled off the top of the accumulator into a word buffer, with a
// 0x00 stuffed after every 0xFF byte when STUFF_EN is set. Full words are
// presented big-endian on a valid/ready output. A flush pads the stream to a
// byte boundary with 1s and emits a final partial word tagged with its byte
// count.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous reset, active low
//   code_i        code value, right-aligned (bits above len_i ignored)
//   len_i         code length in bits (values above MAX_LEN are clamped)
//   code_valid_i  code present
//   code_ready_o  packer can accept a code this cycle
//   flush_i       end-of-stream flush request (level, sampled in RUN)
//   out_data_o    packed word, first byte in the top 8 bits
//   out_valid_o   out_data_o valid
//   out_ready_i   sink accepts the word
//   out_last_o    word is the final word of a flush
//   out_bytes_o   number of valid bytes in out_data_o
//   fill_o        accumulator fill in bits
//   flush_done_o  one-cycle pulse when a flush completes
// ---------------------------------------------------------------------------
module or1200_vlx_packer #(
   parameter int DATA_W   = 32,
   parameter int MAX_LEN  = 16,
   parameter int STUFF_EN = 1,
   parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [MAX_LEN-1:0]               code_i,
   input  logic [LEN_W-1:0]                 len_i,
   input  logic                             code_valid_i,
   output logic                             code_ready_o,
   input  logic                             flush_i,
   output logic [DATA_W-1:0]                out_data_o,
   output logic                             out_valid_o,
   input  logic                             out_ready_i,
   output logic                             out_last_o,
   output logic [$clog2(DATA_W/8+1)-1:0]    out_bytes_o,
   output logic [$clog2(DATA_W+1)-1:0]      fill_o,
   output logic                             flush_done_o
);

   localparam int NB = DATA_W / 8;
   localparam int BW = $clog2(NB + 1);
   localparam int FW = $clog2(DATA_W + 1);
   localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_RUN,
      S_PAD,
      S_DRAIN,
      S_LAST
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] acc;
   logic [FW-1:0]     fill;
   logic [DATA_W-1:0] wbuf;
   logic [BW-1:0]     wcnt;
   logic              stuff_pend;
   logic              out_valid_q;
   logic              out_last_q;
   logic [BW-1:0]     out_bytes_q;
   logic              flush_done_q;

   logic              accept;
   logic [LEN_W-1:0]  len_c;
   logic [LEN_W-1:0]  len_eff;
   logic [DATA_W-1:0] code_mask;
   logic [DATA_W-1:0] code_ext;
   logic [FW-1:0]     ins_sh;
   logic [DATA_W-1:0] ins_bits;
   logic [FW-1:0]     pad_amt;
   logic [DATA_W-1:0] pad_mask;
   logic [DATA_W-1:0] acc_ins;
   logic [FW-1:0]     fill_ins;
   logic              slot_free;
   logic              do_stuff;
   logic              do_extract;
   logic              write_byte;
   logic [7:0]        top_byte;
   logic [7:0]        byte_val;
   logic [DATA_W-1:0] acc_next;
   logic [FW-1:0]     fill_next;
   logic [DATA_W-1:0] wbuf_next;
   logic              handshake;

   // Ready depends only on registered state so the upstream sees a value
   // that is stable for the whole cycle.
   assign code_ready_o = (state == S_RUN) && (fill <= FW'(DATA_W - MAX_LEN));
   assign accept       = code_valid_i && code_ready_o;
   assign handshake    = out_valid_q && out_ready_i;

   // Insertion and padding: the new code (or the pad 1s) land directly below
   // the current fill level, using the fill from before any byte extraction.
   // Bits below the fill are always zero, so OR-ing them in is enough.
   always_comb begin
      len_c     = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
      len_eff   = accept ? len_c : '0;
      code_mask = (ONE << len_eff) - ONE;
      code_ext  = {{(DATA_W-MAX_LEN){1'b0}}, code_i} & code_mask;
      ins_sh    = FW'(DATA_W) - fill - FW'(len_eff);
      ins_bits  = code_ext << ins_sh;
      pad_amt   = (state == S_PAD) ? FW'(3'(3'd0 - fill[2:0])) : '0;
      pad_mask  = ((ONE << pad_amt) - ONE) << (FW'(DATA_W) - fill - pad_amt);
      acc_ins   = acc | ins_bits | pad_mask;
      fill_ins  = fill + FW'(len_eff) + pad_amt;
   end

   // Byte slot: one byte per cycle moves into the word buffer, either a
   // pending stuff 0x00 or the top accumulator byte. The top byte is taken
   // from the pre-insert accumulator, which is identical whenever fill >= 8.
   always_comb begin
      slot_free  = (wcnt != BW'(NB)) && !out_valid_q;
      do_stuff   = slot_free && stuff_pend;
      do_extract = slot_free && !stuff_pend && (fill >= FW'(8));
      write_byte = do_stuff || do_extract;
      top_byte   = acc[DATA_W-1 -: 8];
      byte_val   = do_stuff ? 8'h00 : top_byte;
      acc_next   = do_extract ? (acc_ins << 8) : acc_ins;
      fill_next  = do_extract ? (fill_ins - FW'(8)) : fill_ins;
      wbuf_next  = wbuf | ({byte_val, {(DATA_W-8){1'b0}}} >> {wcnt, 3'b000});
   end

   // Datapath, word buffer and flush sequencer. The word buffer is cleared
   // on every output handshake; the flush FSM walks RUN -> PAD -> DRAIN ->
   // LAST and only leaves DRAIN once every buffered bit, stuff byte and full
   // word has gone out.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state        <= S_RUN;
         acc          <= '0;
         fill         <= '0;
         wbuf         <= '0;
         wcnt         <= '0;
         stuff_pend   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_bytes_q  <= '0;
         flush_done_q <= 1'b0;
      end else begin
         flush_done_q <= 1'b0;
         acc          <= acc_next;
         fill         <= fill_next;

         if (do_stuff) begin
            stuff_pend <= 1'b0;
         end else if (do_extract && (STUFF_EN != 0) && (top_byte == 8'hFF)) begin
            stuff_pend <= 1'b1;
         end

         if (handshake) begin
            wbuf        <= '0;
            wcnt        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_bytes_q <= '0;
         end else if (write_byte) begin
            wbuf <= wbuf_next;
            wcnt <= wcnt + BW'(1);
            if (wcnt == BW'(NB - 1)) begin
               out_valid_q <= 1'b1;
               out_last_q  <= 1'b0;
               out_bytes_q <= BW'(NB);
            end
         end

         case (state)
            S_RUN: begin
               if (flush_i) begin
                  state <= S_PAD;
               end
            end
            S_PAD: begin
               state <= S_DRAIN;
            end
            S_DRAIN: begin
               if ((fill == '0) && !stuff_pend && !out_valid_q) begin
                  state <= S_LAST;
               end
            end
            S_LAST: begin
               if (wcnt == '0) begin
                  flush_done_q <= 1'b1;
                  state        <= S_RUN;
               end else if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b1;
                  out_bytes_q <= wcnt;
               end else if (out_ready_i) begin
                  flush_done_q <= 1'b1;
                  state        <= S_RUN;
               end
            end
            default: begin
               state <= S_RUN;
            end
         endcase
      end
   end

   assign out_data_o   = wbuf;
   assign out_valid_o  = out_valid_q;
   assign out_last_o   = out_last_q;
   assign out_bytes_o  = out_bytes_q;
   assign fill_o       = fill;
   assign flush_done_o = flush_done_q;

endmodule
